// File: rtl/mpc_pkg.sv
// Shared types and helpers for the multi-port FIFO scheduler.
package mpc_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    // Width of a port index; never narrower than one bit.
    function automatic int unsigned port_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: first asserted request at or above ptr, wrapping to index 0.
module rr_pick
    import mpc_pkg::*;
#(
    parameter  int unsigned N = 4,
    localparam int unsigned W = port_w(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] onehot,
    output logic [W-1:0] idx
);

    logic         found;
    logic [W-1:0] j;

    always_comb begin
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        j      = '0;
        for (int unsigned i = 0; i < N; i++) begin
            j = W'((32'(ptr) + i) % N);
            if (!found && req[j]) begin
                found     = 1'b1;
                onehot[j] = 1'b1;
                idx       = j;
            end
        end
    end

endmodule

// File: rtl/fifo_rr_sched.sv
// Round-robin burst scheduler draining NUM_PORTS FWFT FIFOs into one registered stream.
module fifo_rr_sched
    import mpc_pkg::*;
#(
    parameter  int unsigned NUM_PORTS  = 4,
    parameter  int unsigned DATA_WIDTH = 8,
    parameter  int unsigned BURST_LEN  = 4,
    localparam int unsigned PW         = port_w(NUM_PORTS)
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] fifo_dout,
    input  logic [NUM_PORTS-1:0]                 fifo_empty,
    output logic [NUM_PORTS-1:0]                 fifo_rd_en,
    output logic [DATA_WIDTH-1:0]                out_data,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [PW-1:0]                        out_port,
    output logic [NUM_PORTS-1:0]                 grant,
    output logic                                 busy
);

    localparam int unsigned CW = $clog2(BURST_LEN) + 1;

    state_e               state_q;
    logic [PW-1:0]        rr_ptr_q;
    logic [PW-1:0]        gidx_q;
    logic [CW-1:0]        cnt_q;
    logic [NUM_PORTS-1:0] pick_oh;
    logic [PW-1:0]        pick_idx;
    logic [PW-1:0]        nxt_ptr;
    logic                 g_empty;
    logic                 pop;
    logic                 last;

    rr_pick #(
        .N (NUM_PORTS)
    ) u_pick (
        .req    (~fifo_empty),
        .ptr    (rr_ptr_q),
        .onehot (pick_oh),
        .idx    (pick_idx)
    );

    // A pop needs a word at the granted head and room in the output register.
    assign g_empty    = fifo_empty[gidx_q];
    assign pop        = (state_q == BURST) && !g_empty && (!out_valid || out_ready);
    assign fifo_rd_en = pop ? grant : '0;
    assign last       = (cnt_q == CW'(BURST_LEN - 1));
    assign nxt_ptr    = (gidx_q == PW'(NUM_PORTS - 1)) ? '0 : gidx_q + 1'b1;
    assign busy       = (state_q == BURST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            gidx_q    <= '0;
            cnt_q     <= '0;
            grant     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_port  <= '0;
        end else begin
            if (pop) begin
                out_data  <= fifo_dout[gidx_q];
                out_port  <= gidx_q;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (|(~fifo_empty)) begin
                        state_q <= BURST;
                        grant   <= pick_oh;
                        gidx_q  <= pick_idx;
                        cnt_q   <= '0;
                    end
                end
                BURST: begin
                    if (g_empty || (pop && last)) begin
                        state_q  <= IDLE;
                        grant    <= '0;
                        rr_ptr_q <= nxt_ptr;
                    end else if (pop) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
